// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } alarm_state_e;

  localparam int DEF_SNOOZE_MINUTES = 9;
  localparam int DEF_RING_TIMEOUT   = 10;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one-cycle pulse per 0->1 transition of a level.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_level <= 1'b0;
    else       r_level <= i_level;
  end

  assign o_pulse = i_level & ~r_level;

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: BCD alarm time store, minute-tick detection and
// arm/ring/snooze state machine with registered status outputs.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MINUTES = DEF_SNOOZE_MINUTES,
  parameter int RING_TIMEOUT   = DEF_RING_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  input  logic       arm_en,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] alm_min_ones,
  output logic [3:0] alm_min_tens,
  output logic [3:0] alm_hour_ones,
  output logic [3:0] alm_hour_tens,
  output logic       buzzer,
  output logic       armed,
  output logic       snoozing
);

  localparam logic [3:0] LP_SNOOZE  = 4'(SNOOZE_MINUTES);
  localparam logic [3:0] LP_TIMEOUT = 4'(RING_TIMEOUT);

  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] h);
    if (h == 8'h23)           return 8'h00;
    else if (h[3:0] == 4'd9)  return {h[7:4] + 4'd1, 4'd0};
    else                      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] m);
    if (m == 8'h59)           return 8'h00;
    else if (m[3:0] == 4'd9)  return {m[7:4] + 4'd1, 4'd0};
    else                      return {m[7:4], m[3:0] + 4'd1};
  endfunction

  logic         w_inc_hour_p, w_inc_min_p, w_snooze_p, w_stop_p;
  logic [15:0]  w_time;
  logic [15:0]  r_prev_time;
  logic         r_primed;
  logic         r_tick;
  logic [7:0]   r_alm_hour;
  logic [7:0]   r_alm_min;
  logic         w_match;
  logic         w_edit_ok;
  alarm_state_e r_state, w_next_state;
  logic [3:0]   r_ring_cnt, r_snz_cnt;
  logic         w_buzzer_d, w_armed_d, w_snoozing_d;

  rise_detect u_rd_inc_hour (.i_clk(clk), .i_rst(reset), .i_level(inc_hour), .o_pulse(w_inc_hour_p));
  rise_detect u_rd_inc_min  (.i_clk(clk), .i_rst(reset), .i_level(inc_min),  .o_pulse(w_inc_min_p));
  rise_detect u_rd_snooze   (.i_clk(clk), .i_rst(reset), .i_level(snooze),   .o_pulse(w_snooze_p));
  rise_detect u_rd_stop     (.i_clk(clk), .i_rst(reset), .i_level(stop),     .o_pulse(w_stop_p));

  assign w_time    = {hour_tens, hour_ones, min_tens, min_ones};
  assign w_match   = r_tick && (r_prev_time == {r_alm_hour, r_alm_min});
  assign w_edit_ok = set_mode && (r_state == ST_DISARMED || r_state == ST_ARMED);

  // r_primed suppresses a bogus tick against the reset-zero previous time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_time <= 16'h0000;
      r_primed    <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_prev_time <= w_time;
      r_primed    <= 1'b1;
      r_tick      <= r_primed && (w_time != r_prev_time);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alm_hour <= 8'h00;
      r_alm_min  <= 8'h00;
    end else if (w_edit_ok) begin
      if (w_inc_hour_p) r_alm_hour <= bcd_inc_hour(r_alm_hour);
      if (w_inc_min_p)  r_alm_min  <= bcd_inc_min(r_alm_min);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ring_cnt <= 4'd0;
      r_snz_cnt  <= 4'd0;
    end else if (arm_en) begin
      case (r_state)
        ST_ARMED: if (w_match) r_ring_cnt <= 4'd0;
        ST_RINGING: begin
          if (!w_stop_p && w_snooze_p)  r_snz_cnt  <= LP_SNOOZE;
          else if (!w_stop_p && r_tick) r_ring_cnt <= r_ring_cnt + 4'd1;
        end
        ST_SNOOZING: begin
          if (!w_stop_p && r_tick) begin
            r_snz_cnt <= r_snz_cnt - 4'd1;
            if (r_snz_cnt == 4'd1) r_ring_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_DISARMED;
      buzzer   <= 1'b0;
      armed    <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      buzzer   <= w_buzzer_d;
      armed    <= w_armed_d;
      snoozing <= w_snoozing_d;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!arm_en) begin
      w_next_state = ST_DISARMED;
    end else begin
      case (r_state)
        ST_DISARMED: w_next_state = ST_ARMED;
        ST_ARMED:    if (w_match) w_next_state = ST_RINGING;
        ST_RINGING: begin
          if (w_stop_p)        w_next_state = ST_ARMED;
          else if (w_snooze_p) w_next_state = ST_SNOOZING;
          else if (r_tick && (r_ring_cnt + 4'd1 == LP_TIMEOUT)) w_next_state = ST_ARMED;
        end
        ST_SNOOZING: begin
          if (w_stop_p)                         w_next_state = ST_ARMED;
          else if (r_tick && r_snz_cnt == 4'd1) w_next_state = ST_RINGING;
        end
        default: w_next_state = ST_DISARMED;
      endcase
    end
  end

  // Flags are registered from the next state so they track r_state exactly
  always_comb begin
    w_buzzer_d   = (w_next_state == ST_RINGING);
    w_armed_d    = (w_next_state != ST_DISARMED);
    w_snoozing_d = (w_next_state == ST_SNOOZING);
  end

  assign alm_hour_tens = r_alm_hour[7:4];
  assign alm_hour_ones = r_alm_hour[3:0];
  assign alm_min_tens  = r_alm_min[7:4];
  assign alm_min_ones  = r_alm_min[3:0];

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: a minute-of-day reference model
// predicts outputs per cycle; a monitor pops and compares each cycle.
module tb_alarm_controller;

  localparam int SM = 9;
  localparam int RT = 10;
  localparam int M_DIS = 0, M_ARM = 1, M_RING = 2, M_SNZ = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] min_ones, min_tens, hour_ones, hour_tens;
  logic       arm_en, set_mode, inc_hour, inc_min, snooze, stop;
  logic [3:0] alm_min_ones, alm_min_tens, alm_hour_ones, alm_hour_tens;
  logic       buzzer, armed, snoozing;

  always #5 clk = ~clk;

  alarm_controller #(.SNOOZE_MINUTES(SM), .RING_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset),
    .min_ones(min_ones), .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
    .arm_en(arm_en), .set_mode(set_mode), .inc_hour(inc_hour), .inc_min(inc_min),
    .snooze(snooze), .stop(stop),
    .alm_min_ones(alm_min_ones), .alm_min_tens(alm_min_tens),
    .alm_hour_ones(alm_hour_ones), .alm_hour_tens(alm_hour_tens),
    .buzzer(buzzer), .armed(armed), .snoozing(snoozing)
  );

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];
  int cur_time;

  // reference model state (time values are minutes of the day)
  int m_mode, m_alarm, m_prev_time, m_ring_left, m_snz_left;
  bit m_tick, m_started;
  bit pv_ih, pv_im, pv_snz, pv_stop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [18:0] dut_vec();
    return {buzzer, armed, snoozing, alm_hour_tens, alm_hour_ones, alm_min_tens, alm_min_ones};
  endfunction

  function automatic logic [15:0] dut_alarm();
    return {alm_hour_tens, alm_hour_ones, alm_min_tens, alm_min_ones};
  endfunction

  function automatic logic [18:0] model_vec();
    int h, m;
    h = m_alarm / 60;
    m = m_alarm % 60;
    return {m_mode == M_RING, m_mode != M_DIS, m_mode == M_SNZ,
            4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic drive_time();
    int h, m;
    h = cur_time / 60;
    m = cur_time % 60;
    hour_tens = 4'(h / 10);
    hour_ones = 4'(h % 10);
    min_tens  = 4'(m / 10);
    min_ones  = 4'(m % 10);
  endtask

  task automatic model_reset();
    m_mode = M_DIS; m_alarm = 0; m_prev_time = 0; m_ring_left = 0; m_snz_left = 0;
    m_tick = 0; m_started = 0;
    pv_ih = 0; pv_im = 0; pv_snz = 0; pv_stop = 0;
  endtask

  task automatic model_step();
    bit p_ih, p_im, p_snz, p_stop, match, edit_ok;
    p_ih   = inc_hour && !pv_ih;
    p_im   = inc_min  && !pv_im;
    p_snz  = snooze   && !pv_snz;
    p_stop = stop     && !pv_stop;
    pv_ih = inc_hour; pv_im = inc_min; pv_snz = snooze; pv_stop = stop;
    match   = m_tick && (m_prev_time == m_alarm);
    edit_ok = set_mode && (m_mode == M_DIS || m_mode == M_ARM);
    if (!arm_en) m_mode = M_DIS;
    else if (m_mode == M_DIS) m_mode = M_ARM;
    else if (m_mode == M_ARM) begin
      if (match) begin m_mode = M_RING; m_ring_left = RT; end
    end else if (m_mode == M_RING) begin
      if (p_stop) m_mode = M_ARM;
      else if (p_snz) begin m_mode = M_SNZ; m_snz_left = SM; end
      else if (m_tick) begin
        m_ring_left--;
        if (m_ring_left == 0) m_mode = M_ARM;
      end
    end else begin
      if (p_stop) m_mode = M_ARM;
      else if (m_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RT; end
      end
    end
    if (edit_ok) begin
      if (p_ih) m_alarm = (((m_alarm / 60) + 1) % 24) * 60 + (m_alarm % 60);
      if (p_im) m_alarm = (m_alarm / 60) * 60 + ((m_alarm % 60) + 1) % 60;
    end
    m_tick      = m_started && (cur_time != m_prev_time);
    m_prev_time = cur_time;
    m_started   = 1;
  endtask

  // Called at posedge+2: predict the next edge's outputs, then advance one cycle.
  task automatic cyc();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #2;
  endtask

  task automatic minute_tick();
    cur_time = (cur_time + 1) % 1440;
    drive_time();
    cyc();
    cyc();
  endtask

  task automatic ring_at_0700();
    cur_time = 6 * 60 + 59; drive_time(); cyc(); cyc();
    cur_time = 7 * 60;      drive_time(); cyc(); cyc();
  endtask

  initial begin : monitor
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", {13'd0, dut_vec()}, {13'd0, e});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int r;
    arm_en = 0; set_mode = 0; inc_hour = 0; inc_min = 0; snooze = 0; stop = 0;
    cur_time = 6 * 60 + 59;
    drive_time();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", {13'd0, dut_vec()}, 32'd0);
    reset = 0;

    // arm and program alarm 07:00
    arm_en = 1; set_mode = 1;
    cyc(); cyc();
    for (int i = 0; i < 7; i++) begin
      inc_hour = 1; cyc();
      inc_hour = 0; cyc();
    end
    set_mode = 0;
    check("alarm_0700", {16'd0, dut_alarm()}, 32'h0700);
    check("armed_after_arm", {31'd0, armed}, 32'd1);

    // 06:59 -> 07:00 rings one cycle after the tick cycle
    cur_time = 7 * 60; drive_time();
    cyc();
    check("ring_latency_tick_cycle", {31'd0, buzzer}, 32'd0);
    cyc();
    check("ring_on_match", {31'd0, buzzer}, 32'd1);
    check("armed_while_ringing", {31'd0, armed}, 32'd1);

    // snooze, nine ticks, ring again
    snooze = 1; cyc(); snooze = 0; cyc();
    check("snooze_entry", {30'd0, snoozing, buzzer}, 32'h2);
    for (int k = 1; k <= SM; k++) begin
      minute_tick();
      if (k < SM) check("still_snoozing", {31'd0, snoozing}, 32'd1);
      else        check("snooze_expired_rings", {30'd0, buzzer, snoozing}, 32'h2);
    end

    // stop and snooze together: stop wins
    stop = 1; snooze = 1; cyc();
    check("stop_beats_snooze", {29'd0, buzzer, armed, snoozing}, 32'h2);
    stop = 0; snooze = 0; cyc();

    // unattended ring times out after RT ticks
    ring_at_0700();
    check("ring_again", {31'd0, buzzer}, 32'd1);
    for (int k = 1; k <= RT; k++) begin
      minute_tick();
      if (k < RT) check("ringing_before_timeout", {31'd0, buzzer}, 32'd1);
      else        check("ring_timeout", {30'd0, buzzer, armed}, 32'h1);
    end

    // edits ignored while ringing; arm_en low disarms next cycle
    ring_at_0700();
    set_mode = 1; inc_hour = 1; inc_min = 1; cyc();
    inc_hour = 0; inc_min = 0; cyc();
    check("edit_ignored_ringing", {16'd0, dut_alarm()}, 32'h0700);
    check("still_ringing", {31'd0, buzzer}, 32'd1);
    arm_en = 0; cyc();
    check("disarm_from_ring", {30'd0, buzzer, armed}, 32'h0);

    // BCD editing wrap cases while disarmed
    for (int i = 0; i < 59; i++) begin
      inc_min = 1; inc_hour = (i < 16); cyc();
      inc_min = 0; inc_hour = 0;        cyc();
    end
    check("alarm_2359", {16'd0, dut_alarm()}, 32'h2359);
    inc_hour = 1; cyc(); inc_hour = 0; cyc();
    check("hour_wrap", {16'd0, dut_alarm()}, 32'h0059);
    inc_min = 1; cyc(); inc_min = 0; cyc();
    check("min_wrap_no_carry", {16'd0, dut_alarm()}, 32'h0000);
    inc_min = 1; repeat (5) cyc(); inc_min = 0; cyc();
    check("held_inc_once", {16'd0, dut_alarm()}, 32'h0001);
    set_mode = 0;

    // ring at 00:01, snooze, then asynchronous reset mid-snooze
    arm_en = 1; cyc();
    cur_time = 0; drive_time(); cyc(); cyc();
    cur_time = 1; drive_time(); cyc(); cyc();
    check("ring_0001", {31'd0, buzzer}, 32'd1);
    snooze = 1; cyc(); snooze = 0; cyc();
    minute_tick(); minute_tick();
    check("snoozing_before_reset", {31'd0, snoozing}, 32'd1);
    #1;
    reset = 1;
    #1;
    check("async_reset_clears", {13'd0, dut_vec()}, 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #2;
    reset = 0;
    repeat (4) cyc();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if (arm_en) arm_en = ($urandom_range(0, 59) != 0);
      else        arm_en = ($urandom_range(0, 4) == 0);
      set_mode = ($urandom_range(0, 2) == 0);
      inc_hour = ($urandom_range(0, 5) == 0);
      inc_min  = ($urandom_range(0, 5) == 0);
      snooze   = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 3)       cur_time = (m_alarm + 1439) % 1440;
      else if (r < 30) cur_time = (cur_time + 1) % 1440;
      else if (r < 32) cur_time = int'($urandom_range(0, 1439));
      drive_time();
      cyc();
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
